// File: rtl/eth_vlg_pkg.sv
// Shared types for the stream monitor: violation codes and the sticky flag vector.
package eth_vlg_pkg;

  typedef enum logic [2:0] {
    V_SOFIN = 3'd0,
    V_NOSOF = 3'd1,
    V_GAP   = 3'd2,
    V_SHORT = 3'd3,
    V_LONG  = 3'd4,
    V_STALL = 3'd5,
    V_TMO   = 3'd6
  } viol_code_e;

  localparam int unsigned N_VIOL = 7;

  typedef logic [N_VIOL-1:0] mon_flags_t;

  // Lowest set code wins when a channel raises several violations at once.
  function automatic viol_code_e lowest_code(input mon_flags_t f);
    viol_code_e c;
    c = V_SOFIN;
    for (int unsigned i = N_VIOL; i > 0; i--) begin
      if (f[i-1]) c = viol_code_e'(3'(i - 1));
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_vlg_strm_mon_if.sv
// Per-channel byte-stream handshake bundle (val/sof/eof with cts backpressure).
interface eth_vlg_strm_mon_if #(
  parameter int unsigned N_CH = 4
);
  logic [N_CH-1:0] val;
  logic [N_CH-1:0] sof;
  logic [N_CH-1:0] eof;
  logic [N_CH-1:0] cts;

  modport master (output val, sof, eof, input  cts);
  modport slave  (input  val, sof, eof, output cts);
  modport mon    (input  val, sof, eof, cts);
endinterface

// File: rtl/eth_vlg_strm_mon_ch.sv
// One monitored channel: framing FSM, length/idle counters, good-frame count, sticky flags.
module eth_vlg_strm_mon_ch
  import eth_vlg_pkg::*;
#(
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MIN_LEN     = 60,
  parameter int unsigned MAX_LEN     = 1518,
  parameter int unsigned TMO         = 1024,
  parameter int unsigned STRICT_CONT = 0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             val_i,
  input  logic             sof_i,
  input  logic             eof_i,
  input  logic             cts_i,
  input  logic             clr_err_i,
  input  logic             clr_cnt_i,
  output logic [CNT_W-1:0] cnt_o,
  output mon_flags_t       flags_o,
  output mon_flags_t       viol_o
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FRAME = 1'b1;

  localparam int unsigned      TMO_W    = (TMO > 0) ? $clog2(TMO + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LIM  = TMO_W'(TMO);
  localparam logic [LEN_W-1:0] LEN_MIN  = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_LONG = LEN_W'(MAX_LEN + 1);

  logic [0:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, len_inc, ev_len;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             bad_q, bad_d, ev_bad, ev_en;
  logic             stall_q, psof_q, peof_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mon_flags_t       flags_q, flags_d, viol;
  logic             acc, good;

  always_comb begin
    acc     = val_i & cts_i;
    len_inc = (&len_q) ? len_q : len_q + LEN_W'(1);
    state_d = state_q;
    len_d   = len_q;
    tmo_d   = tmo_q;
    bad_d   = bad_q;
    viol    = '0;
    ev_en   = 1'b0;
    ev_len  = len_q;
    ev_bad  = bad_q;

    case (state_q)
      ST_IDLE: begin
        if (acc) begin
          if (sof_i) begin
            len_d   = LEN_W'(1);
            tmo_d   = '0;
            bad_d   = 1'b0;
            ev_en   = eof_i;
            ev_len  = LEN_W'(1);
            ev_bad  = 1'b0;
            state_d = eof_i ? ST_IDLE : ST_FRAME;
          end else begin
            viol[V_NOSOF] = 1'b1;
          end
        end
      end
      default: begin
        if (acc) begin
          tmo_d = '0;
          // A sof inside a frame discards the old frame and restarts cleanly.
          if (sof_i) begin
            viol[V_SOFIN] = 1'b1;
            len_d  = LEN_W'(1);
            bad_d  = 1'b0;
            ev_len = LEN_W'(1);
            ev_bad = 1'b0;
          end else begin
            len_d  = len_inc;
            ev_len = len_inc;
            if (len_inc == LEN_LONG) begin
              viol[V_LONG] = 1'b1;
              bad_d  = 1'b1;
              ev_bad = 1'b1;
            end
          end
          if (eof_i) begin
            ev_en   = 1'b1;
            state_d = ST_IDLE;
          end
        end else begin
          if (STRICT_CONT != 0 && !val_i) viol[V_GAP] = 1'b1;
          if (TMO != 0 && tmo_q == TMO_LIM - TMO_W'(1)) begin
            viol[V_TMO] = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            tmo_d = tmo_q + TMO_W'(1);
          end
        end
      end
    endcase

    viol[V_SHORT] = ev_en && (ev_len < LEN_MIN);
    good          = ev_en && !ev_bad && !(ev_len < LEN_MIN);
    // A stalled beat must be held unchanged until accepted.
    viol[V_STALL] = stall_q && (!val_i || sof_i != psof_q || eof_i != peof_q);

    flags_d = (clr_err_i ? '0 : flags_q) | viol;
    cnt_d   = clr_cnt_i ? '0 : cnt_q;
    if (good && !(&cnt_d)) cnt_d = cnt_d + CNT_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      tmo_q   <= '0;
      bad_q   <= 1'b0;
      stall_q <= 1'b0;
      psof_q  <= 1'b0;
      peof_q  <= 1'b0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      tmo_q   <= tmo_d;
      bad_q   <= bad_d;
      stall_q <= val_i & ~cts_i;
      psof_q  <= sof_i;
      peof_q  <= eof_i;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  assign cnt_o   = cnt_q;
  assign flags_o = flags_q;
  assign viol_o  = viol;

endmodule

// File: rtl/eth_vlg_strm_mon.sv
// Multi-channel stream monitor: per-channel checkers, first-violation capture, irq and readout.
module eth_vlg_strm_mon
  import eth_vlg_pkg::*;
#(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned LEN_W       = 16,
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned MIN_LEN     = 60,
  parameter int unsigned MAX_LEN     = 1518,
  parameter int unsigned TMO         = 1024,
  parameter int unsigned STRICT_CONT = 0,
  localparam int unsigned SEL_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic               clk,
  input  logic               rst,
  eth_vlg_strm_mon_if.mon    strm,
  input  logic               clr_err,
  input  logic               clr_cnt,
  input  logic [SEL_W-1:0]   sel,
  output logic [CNT_W-1:0]   rd_cnt,
  output mon_flags_t         rd_err,
  output logic               irq,
  output logic               first_vld,
  output logic [SEL_W-1:0]   first_ch,
  output logic [2:0]         first_code
);

  logic [CNT_W-1:0] cnt_a   [N_CH];
  mon_flags_t       flags_a [N_CH];
  mon_flags_t       viol_a  [N_CH];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    eth_vlg_strm_mon_ch #(
      .LEN_W       (LEN_W),
      .CNT_W       (CNT_W),
      .MIN_LEN     (MIN_LEN),
      .MAX_LEN     (MAX_LEN),
      .TMO         (TMO),
      .STRICT_CONT (STRICT_CONT)
    ) u_ch (
      .clk_i     (clk),
      .rst_ni    (rst),
      .val_i     (strm.val[g]),
      .sof_i     (strm.sof[g]),
      .eof_i     (strm.eof[g]),
      .cts_i     (strm.cts[g]),
      .clr_err_i (clr_err),
      .clr_cnt_i (clr_cnt),
      .cnt_o     (cnt_a[g]),
      .flags_o   (flags_a[g]),
      .viol_o    (viol_a[g])
    );
  end

  logic             hit, any_flag;
  logic [SEL_W-1:0] hit_ch;
  viol_code_e       hit_code;

  logic [CNT_W-1:0] rd_cnt_q;
  mon_flags_t       rd_err_q;
  logic             irq_q, first_vld_q;
  logic [SEL_W-1:0] first_ch_q;
  viol_code_e       first_code_q;

  // Scan high to low so the lowest violating channel is the last writer.
  always_comb begin
    hit      = 1'b0;
    hit_ch   = '0;
    hit_code = V_SOFIN;
    any_flag = 1'b0;
    for (int unsigned i = N_CH; i > 0; i--) begin
      if (|viol_a[i-1]) begin
        hit      = 1'b1;
        hit_ch   = SEL_W'(i - 1);
        hit_code = lowest_code(viol_a[i-1]);
      end
      any_flag = any_flag | (|flags_a[i-1]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_cnt_q     <= '0;
      rd_err_q     <= '0;
      irq_q        <= 1'b0;
      first_vld_q  <= 1'b0;
      first_ch_q   <= '0;
      first_code_q <= V_SOFIN;
    end else begin
      rd_cnt_q <= (32'(sel) < N_CH) ? cnt_a[sel]   : '0;
      rd_err_q <= (32'(sel) < N_CH) ? flags_a[sel] : '0;
      irq_q    <= any_flag;
      if (!first_vld_q || clr_err) begin
        first_vld_q  <= hit;
        first_ch_q   <= hit_ch;
        first_code_q <= hit_code;
      end
    end
  end

  assign rd_cnt     = rd_cnt_q;
  assign rd_err     = rd_err_q;
  assign irq        = irq_q;
  assign first_vld  = first_vld_q;
  assign first_ch   = first_ch_q;
  assign first_code = first_code_q;

endmodule

// File: tb/tb_eth_vlg_strm_mon.sv
// Randomized and directed bench for eth_vlg_strm_mon against a frame-level reference model.
module tb_eth_vlg_strm_mon;

  localparam int N_CH        = 4;
  localparam int LEN_W       = 16;
  localparam int CNT_W       = 32;
  localparam int MIN_LEN     = 60;
  localparam int MAX_LEN     = 1518;
  localparam int TMO         = 1024;
  localparam int STRICT_CONT = 0;
  localparam int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam longint LEN_SAT = (64'd1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             clr_err, clr_cnt;
  logic [SEL_W-1:0] sel;
  logic [CNT_W-1:0] rd_cnt;
  logic [6:0]       rd_err;
  logic             irq, first_vld;
  logic [SEL_W-1:0] first_ch;
  logic [2:0]       first_code;

  eth_vlg_strm_mon_if #(.N_CH(N_CH)) sif ();

  eth_vlg_strm_mon #(
    .N_CH(N_CH), .LEN_W(LEN_W), .CNT_W(CNT_W), .MIN_LEN(MIN_LEN),
    .MAX_LEN(MAX_LEN), .TMO(TMO), .STRICT_CONT(STRICT_CONT)
  ) dut (
    .clk(clk), .rst(rst), .strm(sif), .clr_err(clr_err), .clr_cnt(clr_cnt),
    .sel(sel), .rd_cnt(rd_cnt), .rd_err(rd_err), .irq(irq),
    .first_vld(first_vld), .first_ch(first_ch), .first_code(first_code)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: one frame tracker per channel.
  bit              m_inf  [N_CH];
  longint          m_len  [N_CH];
  bit              m_bad  [N_CH];
  int              m_idle [N_CH];
  bit              m_pend [N_CH];
  bit              m_psof [N_CH];
  bit              m_peof [N_CH];
  longint unsigned m_cnt  [N_CH];
  logic [6:0]      m_flags[N_CH];
  bit              m_fvld;
  int              m_fch, m_fcode;
  longint unsigned e_rd_cnt;
  logic [6:0]      e_rd_err;
  bit              e_irq;

  int g_len[N_CH];
  int g_pos[N_CH];

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < N_CH; c++) begin
      m_inf[c] = 0; m_len[c] = 0; m_bad[c] = 0; m_idle[c] = 0;
      m_pend[c] = 0; m_psof[c] = 0; m_peof[c] = 0; m_cnt[c] = 0; m_flags[c] = '0;
    end
    m_fvld = 0; m_fch = 0; m_fcode = 0;
    e_rd_cnt = 0; e_rd_err = '0; e_irq = 0;
  endtask

  task automatic model_step();
    logic [6:0] v;
    bit acc, hit;
    int hc, hcode;
    if (!rst) begin
      model_reset();
      return;
    end
    e_rd_cnt = (int'(sel) < N_CH) ? m_cnt[sel] : 0;
    e_rd_err = (int'(sel) < N_CH) ? m_flags[sel] : '0;
    e_irq = 0;
    for (int c = 0; c < N_CH; c++) if (m_flags[c] != 0) e_irq = 1;
    hit = 0; hc = 0; hcode = 0;
    for (int c = 0; c < N_CH; c++) begin
      v = '0;
      acc = sif.val[c] && sif.cts[c];
      if (clr_cnt) m_cnt[c] = 0;
      if (m_pend[c] && (!sif.val[c] || sif.sof[c] != m_psof[c] || sif.eof[c] != m_peof[c])) v[5] = 1;
      m_pend[c] = sif.val[c] && !sif.cts[c];
      m_psof[c] = sif.sof[c];
      m_peof[c] = sif.eof[c];
      if (acc) begin
        m_idle[c] = 0;
        if (sif.sof[c]) begin
          if (m_inf[c]) v[0] = 1;
          m_inf[c] = 1; m_len[c] = 1; m_bad[c] = 0;
        end else if (!m_inf[c]) begin
          v[1] = 1;
        end else begin
          if (m_len[c] < LEN_SAT) m_len[c]++;
          if (m_len[c] == MAX_LEN + 1) begin v[4] = 1; m_bad[c] = 1; end
        end
        if (m_inf[c] && sif.eof[c]) begin
          m_inf[c] = 0;
          if (m_len[c] < MIN_LEN) begin v[3] = 1; m_bad[c] = 1; end
          if (!m_bad[c] && m_cnt[c] < (64'd1 << CNT_W) - 1) m_cnt[c]++;
        end
      end else if (m_inf[c]) begin
        if (STRICT_CONT != 0 && !sif.val[c]) v[2] = 1;
        m_idle[c]++;
        if (TMO != 0 && m_idle[c] == TMO) begin v[6] = 1; m_inf[c] = 0; end
      end
      m_flags[c] = (clr_err ? 7'd0 : m_flags[c]) | v;
      if (!hit && v != 0) begin
        hit = 1; hc = c;
        for (int b = 6; b >= 0; b--) if (v[b]) hcode = b;
      end
    end
    if (!m_fvld || clr_err) begin
      m_fvld = hit; m_fch = hc; m_fcode = hcode;
    end
  endtask

  task automatic check_all();
    chk("rd_cnt", rd_cnt, e_rd_cnt);
    chk("rd_err", rd_err, e_rd_err);
    chk("irq", irq, e_irq);
    chk("first_vld", first_vld, m_fvld);
    chk("first_ch", first_ch, m_fch);
    chk("first_code", first_code, m_fcode);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_all();
    sif.val = '0; sif.sof = '0; sif.eof = '0;
  endtask

  task automatic beat(input int ch, input bit s, input bit e);
    idle_all();
    sif.val[ch] = 1'b1; sif.sof[ch] = s; sif.eof[ch] = e;
    tick();
  endtask

  task automatic frame(input int ch, input int n);
    for (int i = 0; i < n; i++) beat(ch, i == 0, i == n - 1);
    idle_all();
  endtask

  task automatic idle(input int n);
    idle_all();
    repeat (n) tick();
  endtask

  task automatic rand_drive();
    for (int c = 0; c < N_CH; c++) begin
      if (sif.val[c] && sif.cts[c]) begin
        g_pos[c]++;
        if (g_pos[c] >= g_len[c]) g_pos[c] = 0;
      end
      if (!(sif.val[c] && !sif.cts[c] && $urandom_range(0, 99) >= 3)) begin
        if (g_pos[c] == 0) g_len[c] = $urandom_range(40, 80);
        sif.val[c] = ($urandom_range(0, 99) < 80);
        sif.sof[c] = (g_pos[c] == 0) ^ ($urandom_range(0, 99) < 2);
        sif.eof[c] = (g_pos[c] == g_len[c] - 1) ^ ($urandom_range(0, 99) < 2);
      end
      sif.cts[c] = ($urandom_range(0, 99) < 85);
    end
    clr_err = ($urandom_range(0, 199) == 0);
    clr_cnt = ($urandom_range(0, 199) == 0);
    sel     = SEL_W'($urandom_range(0, N_CH - 1));
  endtask

  initial begin
    rst = 1'b0; clr_err = 1'b0; clr_cnt = 1'b0; sel = '0;
    idle_all();
    sif.cts = '1;
    model_reset();
    for (int c = 0; c < N_CH; c++) begin g_len[c] = 0; g_pos[c] = 0; end
    repeat (3) tick();
    chk("reset_rd_cnt", rd_cnt, 0);
    chk("reset_rd_err", rd_err, 0);
    chk("reset_irq", irq, 0);
    chk("reset_first_vld", first_vld, 0);
    rst = 1'b1;

    // Clean 64-beat frame on ch0
    frame(0, 64);
    idle(2);
    chk("ch0_good_cnt", rd_cnt, 1);
    chk("ch0_good_err", rd_err, 0);
    chk("ch0_good_irq", irq, 0);

    // ch1: sof, 10 beats, sof again, then 60 beats to eof
    sel = 1;
    beat(1, 1, 0);
    repeat (10) beat(1, 0, 0);
    beat(1, 1, 0);
    repeat (59) beat(1, 0, 0);
    beat(1, 0, 1);
    idle(2);
    chk("ch1_sofin_err", rd_err, 7'b0000001);
    chk("ch1_sofin_cnt", rd_cnt, 1);
    chk("ch1_first_vld", first_vld, 1);
    chk("ch1_first_ch", first_ch, 1);
    chk("ch1_first_code", first_code, 0);
    chk("ch1_irq", irq, 1);

    // ch2: short frame, then a 1600-beat frame; LONG flagged at beat 1519
    sel = 2;
    frame(2, 20);
    idle(2);
    chk("ch2_short", rd_err, 7'b0001000);
    for (int i = 0; i < 1600; i++) begin
      beat(2, i == 0, i == 1599);
      if (i == 1518) chk("ch2_long_pre", rd_err[4], 0);
      if (i == 1519) chk("ch2_long_at", rd_err[4], 1);
    end
    idle(2);
    chk("ch2_cnt", rd_cnt, 0);

    // ch3: sof then silence until timeout, then a sof-less beat
    sel = 3;
    beat(3, 1, 0);
    idle(TMO);
    idle(1);
    chk("ch3_tmo", rd_err[6], 1);
    beat(3, 0, 0);
    idle(2);
    chk("ch3_nosof", rd_err, 7'b1000010);

    // Same-cycle violations on ch0 and ch2 after clearing
    clr_err = 1'b1;
    idle(1);
    clr_err = 1'b0;
    idle(1);
    chk("clr_first_vld", first_vld, 0);
    idle_all();
    sif.val[0] = 1'b1; sif.val[2] = 1'b1;
    tick();
    idle(1);
    chk("tie_first_ch", first_ch, 0);
    chk("tie_first_code", first_code, 1);

    // Async reset in the middle of a ch0 frame
    sel = 0;
    for (int i = 0; i < 10; i++) beat(0, i == 0, 1'b0);
    rst = 1'b0;
    model_reset();
    #1;
    chk("areset_rd_cnt", rd_cnt, 0);
    chk("areset_rd_err", rd_err, 0);
    chk("areset_irq", irq, 0);
    chk("areset_first_vld", first_vld, 0);
    chk("areset_first_ch", first_ch, 0);
    chk("areset_first_code", first_code, 0);
    idle(1);
    rst = 1'b1;
    frame(0, 64);
    idle(2);
    chk("post_reset_cnt", rd_cnt, 1);

    // clr_err coinciding with a ch1 NOSOF keeps the new flag
    sel = 1;
    frame(1, 5);
    idle(2);
    idle_all();
    sif.val[1] = 1'b1;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    idle(2);
    chk("clr_vs_nosof_err", rd_err, 7'b0000010);
    chk("clr_vs_nosof_ch", first_ch, 1);
    chk("clr_vs_nosof_code", first_code, 1);

    // clr_cnt coinciding with a good eof leaves count at 1
    frame(1, 64);
    for (int i = 0; i < 64; i++) begin
      clr_cnt = (i == 63);
      beat(1, i == 0, i == 63);
    end
    clr_cnt = 1'b0;
    idle(2);
    chk("clr_cnt_eof", rd_cnt, 1);

    // Random traffic with backpressure and occasional framing corruption
    for (int i = 0; i < 3000; i++) begin
      rand_drive();
      tick();
    end
    clr_err = 1'b0; clr_cnt = 1'b0;
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/eth_vlg_strm_mon.md
Name: eth_vlg_strm_mon

Overview:
- Synthesizable multi-channel protocol monitor for the stack's byte-stream interfaces (val/sof/eof with cts backpressure), e.g. MAC rx output and the TCP rx/tx control streams.
- Tracks framing per channel, counts frames, and latches sticky violation flags. Captures the first violation for debug.
- Replaces the per-interface simulation-only checkers with one parametrised, observable-in-silicon block.

Parameters:
N_CH, 4, number of monitored channels (1..16)
LEN_W, 16, frame length counter width
CNT_W, 32, frame counter width
MIN_LEN, 60, minimum legal frame length in accepted beats
MAX_LEN, 1518, maximum legal frame length in accepted beats
TMO, 1024, max idle cycles inside a frame before timeout; 0 disables
STRICT_CONT, 0, 1 = val deassertion mid-frame is a violation

Ports:
clk  in  1  clock
rst  in  1  reset; one clock; reset is asynchronous and active-low
val  in  N_CH  per-channel beat valid
sof  in  N_CH  per-channel start of frame
eof  in  N_CH  per-channel end of frame
cts  in  N_CH  per-channel sink ready; beat accepted when val&cts
clr_err  in  1  pulse: clear sticky flags and first-error capture
clr_cnt  in  1  pulse: clear frame counters
sel  in  $clog2(N_CH) (min 1)  readout channel select
rd_cnt  out  CNT_W  good-frame count of channel sel
rd_err  out  7  sticky flags of channel sel
irq  out  1  OR of all sticky flags, all channels
first_vld  out  1  first violation captured
first_ch  out  $clog2(N_CH) (min 1)  channel of first violation
first_code  out  3  code of first violation

Behaviour:
- Reset (rst low, async): all FSMs IDLE, length/timeout/frame counters 0, flags 0, outputs 0.
- Per-channel FSM has two states, IDLE and FRAME. Accepted beat acc = val&cts.
- IDLE: acc&sof&eof -> single-beat frame, len=1, evaluate at eof, stay IDLE. acc&sof -> FRAME, len=1. acc&!sof -> flag NOSOF (code 1), stay IDLE.
- FRAME: acc -> len+1, saturating at all-ones. acc&sof -> flag SOFIN (code 0), abort current frame (not counted), restart with len=1, stay FRAME; if eof is also set, evaluate as a single-beat frame and go to IDLE. acc&eof -> evaluate, go to IDLE.
- eof evaluation uses final len including the eof beat.
  - len<MIN_LEN -> SHORT (code 3).
  - len>MAX_LEN -> LONG (code 4), flagged once per frame, as soon as len reaches MAX_LEN+1.
  - Frame with no SHORT/LONG/SOFIN raised during it -> good; frame counter +1, saturating.
- STALL (code 5): val&!cts while sof, eof or data changes relative to the previous stalled cycle, i.e. the source withdrew or altered a pending beat. The block compares sof/eof only.
- GAP (code 2): STRICT_CONT=1 and FRAME and !val.
- TMO (code 6): FRAME and no acc for TMO consecutive cycles -> flag, return to IDLE, frame not counted. The idle counter resets on every acc.
- Flags are sticky; bit i = code i.
  - clr_err clears them.
  - Simultaneous clr_err and new violation: the new violation is set.
  - clr_cnt clears frame counters; a simultaneous good eof leaves count 1.
- First capture: the first violation after reset/clr_err loads first_ch/first_code and sets first_vld. If several occur in the same cycle, the lowest channel wins, then the lowest code. Later violations are ignored until clr_err.
- Readout: rd_cnt and rd_err are registered, 1-cycle latency from sel. irq is registered, 1 cycle after the flag is set.
- Flag updates take effect the cycle after the violating beat.

Decomposition:
- eth_vlg_pkg holds the violation code enum (SOFIN, NOSOF, GAP, SHORT, LONG, STALL, TMO) and a mon_flags_t typedef.
- Natural sub-module: eth_vlg_strm_mon_ch, the per-channel FSM, counters and flags, instanced N_CH times by generate.
- The top holds the first-error priority encoder, irq OR and readout mux.

Test Plan:
- Ch0 sends a 64-beat frame, cts=1 -> rd_cnt(sel=0)=1, rd_err=0, irq=0.
- Ch1 sends sof, 10 beats, then sof again, then 60 beats to eof -> SOFIN set, first_ch=1, first_code=0, rd_cnt(ch1)=1.
- Ch2 sends a 20-beat frame -> SHORT. Ch2 then sends a 1600-beat frame -> LONG asserted at beat 1519. rd_cnt(ch2)=0.
- Ch3 sends sof then stalls 1024 cycles (TMO=1024) -> TMO set, FSM back to IDLE. A following beat without sof -> NOSOF.
- Ch0 and ch2 violate in the same cycle -> first_ch=0. Assert rst low mid-frame -> all outputs 0 immediately, and a clean frame afterwards counts 1.
- clr_err pulsed in the same cycle as a ch1 NOSOF -> flag remains set. Then clr_cnt with a simultaneous good eof -> rd_cnt=1.
